// File: rtl/bus_narrower_26_8.sv
// Wide-to-narrow serializer: one IN_W-bit word in, ceil(IN_W/OUT_W) OUT_W-bit beats out.
// Define BUS_NARROWER_PARITY_EN to add the registered even-parity output out_par.
module bus_narrower_26_8 #(
   parameter int IN_W      = 26,
   parameter int OUT_W     = 8,
   parameter int MSB_FIRST = 0,
   localparam int BEATS    = (IN_W + OUT_W - 1) / OUT_W,
   localparam int PW       = BEATS * OUT_W,
   localparam int BW       = (BEATS > 1) ? $clog2(BEATS) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic [BW-1:0]    out_idx
`ifdef BUS_NARROWER_PARITY_EN
   ,
   output logic             out_par
`endif
);

   typedef enum logic {IDLE, SEND} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] shreg_q, shreg_d;
   logic [BW-1:0] idx_d;
   logic          last_d;
   logic          xfer;
   logic          accept;

   // The beat on the wire is always the transmit-side end of the shift register.
   function automatic logic [OUT_W-1:0] front_beat(input logic [PW-1:0] w);
      return (MSB_FIRST != 0) ? w[PW-1 -: OUT_W] : w[OUT_W-1:0];
   endfunction

   assign out_valid = (state_q == SEND);
   assign xfer      = out_valid && out_ready;
   assign in_ready  = (state_q == IDLE) || (xfer && out_last);
   assign accept    = in_valid && in_ready;
   assign out_data  = front_beat(shreg_q);

   always_comb begin
      // NOTE: every signal gets a default first so no branch leaves it unassigned (no latch).
      state_d = state_q;
      shreg_d = shreg_q;
      idx_d   = out_idx;
      last_d  = out_last;
      if (accept) begin
         // Entered from IDLE or on the final beat, which gives gap-free back-to-back words.
         state_d = SEND;
         shreg_d = PW'(in_data);
         idx_d   = '0;
         last_d  = (BEATS == 1);
      end else if (xfer && !out_last) begin
         shreg_d = (MSB_FIRST != 0) ? (shreg_q << OUT_W) : (shreg_q >> OUT_W);
         idx_d   = out_idx + BW'(1);
         last_d  = (idx_d == BW'(BEATS - 1));
      end else if (xfer) begin
         state_d = IDLE;
         idx_d   = '0;
         last_d  = 1'b0;
      end
   end

`ifdef BUS_NARROWER_PARITY_EN
   logic [OUT_W-1:0] beat_d;
   assign beat_d = front_beat(shreg_d);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         shreg_q  <= '0;
         out_idx  <= '0;
         out_last <= 1'b0;
`ifdef BUS_NARROWER_PARITY_EN
         out_par  <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         out_idx  <= idx_d;
         out_last <= last_d;
`ifdef BUS_NARROWER_PARITY_EN
         out_par  <= ^beat_d;
`endif
      end
   end

endmodule

// File: tb/tb_bus_narrower_26_8.sv
// Bench for bus_narrower_26_8: LSB-first and MSB-first instances, table of words with
// hand-derived beats, scoreboard queue per instance, plus backpressure/back-to-back/reset sequences.
module tb_bus_narrower_26_8;

   typedef struct packed {
      logic [25:0]     word;
      logic [3:0][7:0] beats;  // beats[i] = byte i of the zero-padded word
      logic [3:0]      par;    // par[i]  = even parity of beats[i]
   } vec_t;

   typedef struct packed {
      logic [7:0] data;
      logic [1:0] idx;
      logic       last;
      logic       par;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [25:0] in_data0, in_data1;
   logic        in_valid0, in_valid1;
   logic        in_ready0, in_ready1;
   logic [7:0]  out_data0, out_data1;
   logic        out_valid0, out_valid1;
   logic        out_ready0, out_ready1;
   logic        out_last0, out_last1;
   logic [1:0]  out_idx0, out_idx1;
`ifdef BUS_NARROWER_PARITY_EN
   logic        out_par0, out_par1;
`endif

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb0[$];
   exp_t sb1[$];
   vec_t vecs[6];

   bus_narrower_26_8 #(.IN_W(26), .OUT_W(8), .MSB_FIRST(0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
      .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready0),
      .out_last(out_last0), .out_idx(out_idx0)
`ifdef BUS_NARROWER_PARITY_EN
      , .out_par(out_par0)
`endif
   );

   bus_narrower_26_8 #(.IN_W(26), .OUT_W(8), .MSB_FIRST(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
      .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
      .out_last(out_last1), .out_idx(out_idx1)
`ifdef BUS_NARROWER_PARITY_EN
      , .out_par(out_par1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_word(input int which, input vec_t v);
      exp_t e;
      for (int k = 0; k < 4; k++) begin
         int b;
         b      = (which == 1) ? 3 - k : k;
         e.data = v.beats[b];
         e.idx  = 2'(k);
         e.last = (k == 3);
         e.par  = v.par[b];
         if (which == 1) sb1.push_back(e);
         else            sb0.push_back(e);
      end
   endtask

   // Caller positions itself just after a rising edge; returns just after the accept edge.
   task automatic send_word(input int which, input vec_t v);
      logic ok;
      ok = 1'b0;
      if (which == 1) begin in_data1 = v.word; in_valid1 = 1'b1; end
      else            begin in_data0 = v.word; in_valid0 = 1'b1; end
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if ((which == 1) ? in_ready1 : in_ready0) begin
            push_word(which, v);
            ok = 1'b1;
            break;
         end
      end
      check("accept_timeout", 32'(ok), 32'd1);
      @(posedge clk);
      #1;
      if (which == 1) in_valid1 = 1'b0;
      else            in_valid0 = 1'b0;
   endtask

   task automatic drain(input int which);
      for (int c = 0; c < 50; c++) begin
         @(posedge clk);
         #1;
         if (which == 1 && sb1.size() == 0 && !out_valid1) break;
         if (which == 0 && sb0.size() == 0 && !out_valid0) break;
      end
      if (which == 1) begin
         check("drain1_left", sb1.size(), 0);
         check("drain1_idle", 32'(out_valid1), 0);
      end else begin
         check("drain0_left", sb0.size(), 0);
         check("drain0_idle", 32'(out_valid0), 0);
      end
   endtask

   task automatic wait_state0(input logic want_last, input logic [1:0] want_idx);
      logic ok;
      ok = 1'b0;
      for (int c = 0; c < 50; c++) begin
         @(posedge clk);
         #1;
         if (out_valid0 && out_last0 == want_last && out_idx0 == want_idx) begin
            ok = 1'b1;
            break;
         end
      end
      check("wait_timeout", 32'(ok), 32'd1);
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid0 && out_ready0) begin
            if (sb0.size() == 0) check("beat0_unexpected", 32'd1, 32'd0);
            else begin
               e = sb0.pop_front();
               check("beat0_data", 32'(out_data0), 32'(e.data));
               check("beat0_idx",  32'(out_idx0),  32'(e.idx));
               check("beat0_last", 32'(out_last0), 32'(e.last));
`ifdef BUS_NARROWER_PARITY_EN
               check("beat0_par",  32'(out_par0),  32'(e.par));
`endif
            end
         end
         if (rst_n && out_valid1 && out_ready1) begin
            if (sb1.size() == 0) check("beat1_unexpected", 32'd1, 32'd0);
            else begin
               e = sb1.pop_front();
               check("beat1_data", 32'(out_data1), 32'(e.data));
               check("beat1_idx",  32'(out_idx1),  32'(e.idx));
               check("beat1_last", 32'(out_last1), 32'(e.last));
`ifdef BUS_NARROWER_PARITY_EN
               check("beat1_par",  32'(out_par1),  32'(e.par));
`endif
            end
         end
      end
   endtask

   initial begin
      vecs[0] = '{26'h3ABCDEF, {8'h03, 8'hAB, 8'hCD, 8'hEF}, 4'b0111};
      vecs[1] = '{26'h0000155, {8'h00, 8'h00, 8'h01, 8'h55}, 4'b0010};
      vecs[2] = '{26'h3FFFFFF, {8'h03, 8'hFF, 8'hFF, 8'hFF}, 4'b0000};
      vecs[3] = '{26'h1234567, {8'h01, 8'h23, 8'h45, 8'h67}, 4'b1111};
      vecs[4] = '{26'h0000000, {8'h00, 8'h00, 8'h00, 8'h00}, 4'b0000};
      vecs[5] = '{26'h2000001, {8'h02, 8'h00, 8'h00, 8'h01}, 4'b1001};

      rst_n = 1'b0;
      in_data0 = '0; in_valid0 = 1'b0; out_ready0 = 1'b1;
      in_data1 = '0; in_valid1 = 1'b0; out_ready1 = 1'b1;
      #12;
      check("rst_valid",  32'(out_valid0), 0);
      check("rst_data",   32'(out_data0),  0);
      check("rst_last",   32'(out_last0),  0);
      check("rst_idx",    32'(out_idx0),   0);
      check("rst_ready",  32'(in_ready0),  1);
      check("rst_data1",  32'(out_data1),  0);
`ifdef BUS_NARROWER_PARITY_EN
      check("rst_par",    32'(out_par0),   0);
`endif
      #3 rst_n = 1'b1;
      fork monitor(); join_none
      @(posedge clk);
      #1;

      // Table: each word through both beat orders, full-rate drain.
      for (int i = 0; i < 6; i++) begin
         send_word(0, vecs[i]);
         drain(0);
         send_word(1, vecs[i]);
         drain(1);
      end

      // Backpressure on beat 1: data/idx/last held, no input accepted.
      send_word(0, vecs[0]);
      wait_state0(1'b0, 2'd1);
      out_ready0 = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("bp_data",  32'(out_data0),  32'h00CD);
         check("bp_idx",   32'(out_idx0),   1);
         check("bp_last",  32'(out_last0),  0);
         check("bp_ready", 32'(in_ready0),  0);
         check("bp_valid", 32'(out_valid0), 1);
      end
      @(posedge clk);
      #1 out_ready0 = 1'b1;
      drain(0);

      // Back-to-back: second word offered during the last beat of the first.
      send_word(0, vecs[0]);
      wait_state0(1'b1, 2'd3);
      send_word(0, vecs[1]);
      check("b2b_valid", 32'(out_valid0), 1);
      check("b2b_idx",   32'(out_idx0),   0);
      check("b2b_data",  32'(out_data0),  32'h0055);
      drain(0);

      // Asynchronous reset mid-word.
      send_word(0, vecs[0]);
      wait_state0(1'b0, 2'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(out_valid0), 0);
      check("mid_rst_data",  32'(out_data0),  0);
      check("mid_rst_last",  32'(out_last0),  0);
      check("mid_rst_idx",   32'(out_idx0),   0);
      sb0.delete();
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         check("post_rst_ready", 32'(in_ready0),  1);
         check("post_rst_valid", 32'(out_valid0), 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
